// File: rtl/cursor_key_decoder.sv
// PS/2 set-2 cursor key decoder: tracks E0/F0 prefixes and issues clamped
// single-cycle increase/decrease/clear/load pulses to the cursor counter.
module cursor_key_decoder #(
  parameter int WIDTH   = 6,
  parameter int MAX_POS = 63
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [7:0]       scan_code,
  input  logic             scan_valid,
  input  logic [WIDTH-1:0] pos,
  output logic             increase,
  output logic             decrease,
  output logic             clear,
  output logic             parallel,
  output logic [WIDTH-1:0] load,
  output logic             blocked
);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_BKSP  = 8'h66;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_HOME  = 8'h6C;
  localparam logic [7:0] CODE_END   = 8'h69;

  localparam logic [WIDTH:0]   MAX_E    = (WIDTH+1)'(MAX_POS);
  localparam logic [WIDTH:0]   ONE_E    = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] LOAD_MAX = WIDTH'(MAX_POS);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  typedef enum logic [2:0] {CMD_NONE, CMD_LEFT, CMD_RIGHT, CMD_HOME, CMD_END} cmd_t;

  state_t           state_q, state_d;
  cmd_t             cmd_s;
  logic [WIDTH:0]   eff_s;
  logic             inc_q, dec_q, clr_q, par_q, blk_q;
  logic             inc_d, dec_d, clr_d, par_d, blk_d;
  logic [WIDTH-1:0] load_q, load_d;

  // Prefix tracking and command recognition for the byte accepted this cycle.
  always_comb begin
    state_d = state_q;
    cmd_s   = CMD_NONE;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          if (scan_code == CODE_EXT)       state_d = EXT;
          else if (scan_code == CODE_BRK)  state_d = BRK;
          else if (scan_code == CODE_BKSP) cmd_s   = CMD_LEFT;
          else                             state_d = IDLE;
        end
        EXT: begin
          state_d = IDLE;
          case (scan_code)
            CODE_BRK:   state_d = EXT_BRK;
            CODE_EXT:   state_d = EXT;
            CODE_LEFT:  cmd_s   = CMD_LEFT;
            CODE_RIGHT: cmd_s   = CMD_RIGHT;
            CODE_HOME:  cmd_s   = CMD_HOME;
            CODE_END:   cmd_s   = CMD_END;
            default:    cmd_s   = CMD_NONE;
          endcase
        end
        BRK:     state_d = IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // The counter output lags our pulse by one cycle, so fold the pulse in.
  always_comb begin
    if (inc_q)      eff_s = {1'b0, pos} + ONE_E;
    else if (dec_q) eff_s = {1'b0, pos} - ONE_E;
    else if (clr_q) eff_s = '0;
    else if (par_q) eff_s = MAX_E;
    else            eff_s = {1'b0, pos};
  end

  // Clamp the recognised command against the effective position.
  always_comb begin
    inc_d  = 1'b0;
    dec_d  = 1'b0;
    clr_d  = 1'b0;
    par_d  = 1'b0;
    blk_d  = 1'b0;
    load_d = '0;
    case (cmd_s)
      CMD_LEFT: begin
        if (eff_s == '0) blk_d = 1'b1;
        else             dec_d = 1'b1;
      end
      CMD_RIGHT: begin
        if (eff_s == MAX_E) blk_d = 1'b1;
        else                inc_d = 1'b1;
      end
      CMD_HOME: clr_d = 1'b1;
      CMD_END: begin
        par_d  = 1'b1;
        load_d = LOAD_MAX;
      end
      default: blk_d = 1'b0;
    endcase
  end

  // State and registered command outputs.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      clr_q   <= 1'b0;
      par_q   <= 1'b0;
      blk_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      clr_q   <= clr_d;
      par_q   <= par_d;
      blk_q   <= blk_d;
      load_q  <= load_d;
    end
  end

  assign increase = inc_q;
  assign decrease = dec_q;
  assign clear    = clr_q;
  assign parallel = par_q;
  assign blocked  = blk_q;
  assign load     = load_q;

endmodule

// File: tb/tb_cursor_key_decoder.sv
// Self-checking bench for cursor_key_decoder: directed vector table, reset
// corner cases, and a randomized run against a byte-sequence reference model.
module tb_cursor_key_decoder;

  localparam int MAXP = 63;
  localparam logic [4:0] P0  = 5'b00000;
  localparam logic [4:0] INC = 5'b10000;
  localparam logic [4:0] DEC = 5'b01000;
  localparam logic [4:0] CLRP = 5'b00100;
  localparam logic [4:0] PAR = 5'b00010;
  localparam logic [4:0] BLK = 5'b00001;

  logic       CLK, CLR, scan_valid;
  logic [7:0] scan_code;
  logic [5:0] pos, load;
  logic       increase, decrease, clear, parallel, blocked;

  int n_vec = 0;
  int n_bad = 0;

  cursor_key_decoder #(.WIDTH(6), .MAX_POS(63)) dut (
    .CLK(CLK), .CLR(CLR), .scan_code(scan_code), .scan_valid(scan_valid),
    .pos(pos), .increase(increase), .decrease(decrease), .clear(clear),
    .parallel(parallel), .load(load), .blocked(blocked)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic [5:0] p;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [7:0] c, input logic [5:0] p,
                              input logic [4:0] e);
    vec_t r;
    r.v = v; r.code = c; r.p = p; r.exp = e;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [7:0] c, input logic [5:0] p);
    scan_valid = v;
    scan_code  = c;
    pos        = p;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] got;
    logic [5:0] exp_load;
    got      = {increase, decrease, clear, parallel, blocked};
    exp_load = exp[1] ? 6'd63 : 6'd0;
    n_vec++;
    if (got !== exp || load !== exp_load) begin
      n_bad++;
      $display("FAIL %s: got pulses=%b load=%0d, expected pulses=%b load=%0d",
               name, got, load, exp, exp_load);
    end
  endtask

  // Reference model: the bytes of the sequence in progress, decoded as a whole.
  logic [7:0] seq[$];

  function automatic int model_byte(input logic [7:0] b);
    int cmd;
    bit done;
    cmd  = 0;
    done = 1'b1;
    if (seq.size() == 1 && seq[0] == 8'hE0 && b == 8'hE0) return 0;
    seq.push_back(b);
    if (seq.size() == 1) begin
      if (b == 8'hE0 || b == 8'hF0) done = 1'b0;
      else if (b == 8'h66) cmd = 1;
    end else if (seq.size() == 2 && seq[0] == 8'hE0) begin
      if (b == 8'hF0) done = 1'b0;
      else if (b == 8'h6B) cmd = 1;
      else if (b == 8'h74) cmd = 2;
      else if (b == 8'h6C) cmd = 3;
      else if (b == 8'h69) cmd = 4;
    end
    if (done) seq.delete();
    return cmd;
  endfunction

  task automatic do_reset();
    CLR = 1'b0;
    scan_valid = 1'b0;
    scan_code = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b1;
    seq.delete();
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [4:0] prev, expv;
    logic [7:0] b;
    logic       v;
    int cnt, cmd, e;

    pos = 6'd0;
    do_reset();
    check("reset_state", P0);

    // Directed table, applied in order; pos is the lagging counter value.
    vecs.push_back(mk(1, 8'hE0, 6'd62, P0));
    vecs.push_back(mk(1, 8'h74, 6'd62, INC));
    vecs.push_back(mk(1, 8'hE0, 6'd62, P0));
    vecs.push_back(mk(1, 8'h74, 6'd63, BLK));
    vecs.push_back(mk(1, 8'h66, 6'd0,  BLK));
    vecs.push_back(mk(1, 8'hE0, 6'd5,  P0));
    vecs.push_back(mk(1, 8'h6B, 6'd5,  DEC));
    vecs.push_back(mk(1, 8'hE0, 6'd4,  P0));
    vecs.push_back(mk(1, 8'h69, 6'd4,  PAR));
    vecs.push_back(mk(1, 8'hE0, 6'd63, P0));
    vecs.push_back(mk(1, 8'h6C, 6'd63, CLRP));
    vecs.push_back(mk(0, 8'h00, 6'd0,  P0));
    vecs.push_back(mk(1, 8'hE0, 6'd0,  P0));
    vecs.push_back(mk(1, 8'hF0, 6'd0,  P0));
    vecs.push_back(mk(1, 8'h74, 6'd0,  P0));
    vecs.push_back(mk(1, 8'hF0, 6'd0,  P0));
    vecs.push_back(mk(1, 8'h66, 6'd0,  P0));
    vecs.push_back(mk(1, 8'h66, 6'd1,  DEC));
    vecs.push_back(mk(1, 8'h66, 6'd1,  BLK));
    vecs.push_back(mk(1, 8'hE0, 6'd0,  P0));
    vecs.push_back(mk(1, 8'h1C, 6'd0,  P0));
    vecs.push_back(mk(1, 8'h74, 6'd0,  P0));
    vecs.push_back(mk(1, 8'hE0, 6'd10, P0));
    vecs.push_back(mk(1, 8'h6C, 6'd10, CLRP));
    vecs.push_back(mk(1, 8'h66, 6'd10, BLK));
    vecs.push_back(mk(1, 8'hE0, 6'd0,  P0));
    vecs.push_back(mk(1, 8'h69, 6'd0,  PAR));
    vecs.push_back(mk(1, 8'h66, 6'd0,  DEC));
    vecs.push_back(mk(1, 8'hE0, 6'd62, P0));
    vecs.push_back(mk(1, 8'hE0, 6'd62, P0));
    vecs.push_back(mk(1, 8'h74, 6'd62, INC));
    vecs.push_back(mk(1, 8'hE0, 6'd10, P0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 8'h74, 6'd10, P0));
    vecs.push_back(mk(1, 8'h74, 6'd10, INC));
    vecs.push_back(mk(0, 8'hE0, 6'd10, P0));
    vecs.push_back(mk(1, 8'h74, 6'd10, P0));
    vecs.push_back(mk(1, 8'hE0, 6'd10, P0));
    vecs.push_back(mk(1, 8'hF0, 6'd10, P0));
    vecs.push_back(mk(1, 8'hE0, 6'd10, P0));
    vecs.push_back(mk(1, 8'h74, 6'd10, P0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].code, vecs[i].p);
      check($sformatf("table_%0d", i), vecs[i].exp);
    end

    // Reset during EXT discards the prefix.
    drive(1'b1, 8'hE0, 6'd5);
    check("ext_before_reset", P0);
    CLR = 1'b0;
    #1;
    check("reset_mid_ext", P0);
    @(negedge CLK);
    CLR = 1'b1;
    drive(1'b1, 8'h6B, 6'd5);
    check("6b_after_reset", P0);

    // Reset drops an in-flight pulse at once.
    drive(1'b1, 8'h66, 6'd5);
    check("dec_before_reset", DEC);
    CLR = 1'b0;
    #1;
    check("reset_drops_pulse", P0);
    @(negedge CLK);
    CLR = 1'b1;
    drive(1'b1, 8'hE0, 6'd5);
    check("ext_after_reset", P0);
    drive(1'b1, 8'h74, 6'd5);
    check("inc_after_reset", INC);

    // Randomized run; pos comes from a counter fed by the model's own pulses.
    pool = '{8'hE0, 8'hF0, 8'h66, 8'h6B, 8'h74, 8'h6C, 8'h69, 8'h1C};
    do_reset();
    cnt  = 30;
    prev = P0;
    for (int i = 0; i < 3000; i++) begin
      int k;
      v = ($urandom % 5) != 0;
      k = $urandom % 10;
      b = (k < 8) ? pool[k] : 8'($urandom);
      if (prev == P0 && ($urandom % 16) == 0) cnt = $urandom % 64;
      cmd = v ? model_byte(b) : 0;
      e = cnt;
      if (prev[4]) e = cnt + 1;
      if (prev[3]) e = cnt - 1;
      if (prev[2]) e = 0;
      if (prev[1]) e = MAXP;
      case (cmd)
        1:       expv = (e <= 0) ? BLK : DEC;
        2:       expv = (e >= MAXP) ? BLK : INC;
        3:       expv = CLRP;
        4:       expv = PAR;
        default: expv = P0;
      endcase
      drive(v, b, 6'(cnt));
      check($sformatf("rand_%0d", i), expv);
      if (prev[4]) cnt = cnt + 1;
      if (prev[3]) cnt = cnt - 1;
      if (prev[2]) cnt = 0;
      if (prev[1]) cnt = MAXP;
      prev = expv;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
